// File: rtl/game_logic_if.sv
// Host/display bundle for the hangman core: guess/word/button in, letter/LED/count status out.
interface game_logic_if;
  logic [7:0]  guess;
  logic [39:0] setWord;
  logic        toggle_state;
  logic [7:0]  letter;
  logic        red;
  logic        green;
  logic        mistake;
  logic        red_busy;
  logic        game_rdy;
  logic [2:0]  incorrect;
  logic [2:0]  correct;
  logic [4:0]  indexCorrect;

  modport master (
    output guess, setWord, toggle_state,
    input  letter, red, green, mistake, red_busy, game_rdy, incorrect, correct, indexCorrect
  );

  modport slave (
    input  guess, setWord, toggle_state,
    output letter, red, green, mistake, red_busy, game_rdy, incorrect, correct, indexCorrect
  );
endinterface

// File: rtl/game_logic.sv
// Hangman core: latches a 5-letter word, checks each new guess one position per cycle.
// Optional GAME_LOGIC_CASE_FOLD_EN folds lowercase guesses to uppercase before use.
module game_logic #(
  parameter int MAX_MISTAKES = 6
) (
  input  logic       clk,
  input  logic       nRst,
  game_logic_if.slave bus
);

  typedef enum logic [2:0] {SET, IDLE, L0, L1, L2, L3, L4, STOP} state_t;

  state_t      state, state_nxt;
  logic [39:0] word;
  logic [7:0]  last_guess;
  logic [7:0]  letter;
  logic        btn_q, btn_armed, pending, hit;
  logic        red, green, mistake;
  logic [2:0]  incorrect, correct;
  logic [4:0]  index_correct;

  logic [7:0]  guess_f, cur_letter;
  logic [4:0]  pos_mask, idx_nxt;
  logic        btn_rise, take_guess, match, hit_nxt, comparing;
  logic [2:0]  inc_nxt;

  function automatic logic [7:0] fold_case(input logic [7:0] g);
`ifdef GAME_LOGIC_CASE_FOLD_EN
    return (g >= 8'h61 && g <= 8'h7A) ? (g & 8'hDF) : g;
`else
    return g;
`endif
  endfunction

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]);
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= 3'(MAX_MISTAKES)) ? 3'(MAX_MISTAKES) : v + 3'd1;
  endfunction

  // Button must be seen low once after reset before a press counts.
  assign btn_rise   = bus.toggle_state & ~btn_q & btn_armed;
  assign guess_f    = fold_case(bus.guess);
  assign take_guess = pending || (guess_f != last_guess);

  always_comb begin
    cur_letter = 8'h00;
    pos_mask   = 5'b00000;
    comparing  = 1'b0;
    case (state)
      L0: begin cur_letter = word[39:32]; pos_mask = 5'b10000; comparing = 1'b1; end
      L1: begin cur_letter = word[31:24]; pos_mask = 5'b01000; comparing = 1'b1; end
      L2: begin cur_letter = word[23:16]; pos_mask = 5'b00100; comparing = 1'b1; end
      L3: begin cur_letter = word[15:8];  pos_mask = 5'b00010; comparing = 1'b1; end
      L4: begin cur_letter = word[7:0];   pos_mask = 5'b00001; comparing = 1'b1; end
      default: ;
    endcase
    match   = comparing && (last_guess == cur_letter);
    idx_nxt = index_correct | (match ? pos_mask : 5'b00000);
    hit_nxt = hit | match;
    inc_nxt = hit_nxt ? incorrect : sat_inc(incorrect);

    state_nxt = state;
    case (state)
      SET:  if (btn_rise) state_nxt = IDLE;
      IDLE: if (take_guess) state_nxt = L0;
      L0:   state_nxt = L1;
      L1:   state_nxt = L2;
      L2:   state_nxt = L3;
      L3:   state_nxt = L4;
      L4:   state_nxt = (idx_nxt == 5'b11111 || inc_nxt == 3'(MAX_MISTAKES)) ? STOP : IDLE;
      STOP: if (btn_rise) state_nxt = SET;
      default: state_nxt = SET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRst) state <= SET;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      word          <= '0;
      last_guess    <= '0;
      letter        <= '0;
      btn_q         <= 1'b0;
      btn_armed     <= 1'b0;
      pending       <= 1'b0;
      hit           <= 1'b0;
      red           <= 1'b0;
      green         <= 1'b0;
      mistake       <= 1'b0;
      incorrect     <= '0;
      correct       <= '0;
      index_correct <= '0;
    end else begin
      btn_q     <= bus.toggle_state;
      btn_armed <= btn_armed | ~bus.toggle_state;
      mistake   <= 1'b0;
      case (state)
        SET: if (btn_rise) begin
          word          <= bus.setWord;
          incorrect     <= '0;
          correct       <= '0;
          index_correct <= '0;
          red           <= 1'b0;
          green         <= 1'b0;
          pending       <= 1'b1;
        end
        IDLE: if (take_guess) begin
          last_guess <= guess_f;
          letter     <= guess_f;
          pending    <= 1'b0;
          hit        <= 1'b0;
        end
        L0, L1, L2, L3: begin
          index_correct <= idx_nxt;
          hit           <= hit_nxt;
        end
        // Last position: publish the verdict of the whole guess.
        L4: begin
          index_correct <= idx_nxt;
          hit           <= hit_nxt;
          correct       <= popcount5(idx_nxt);
          incorrect     <= inc_nxt;
          red           <= ~hit_nxt;
          green         <= hit_nxt;
          mistake       <= ~hit_nxt;
        end
        STOP: if (btn_rise) begin
          letter        <= '0;
          incorrect     <= '0;
          correct       <= '0;
          index_correct <= '0;
          red           <= 1'b0;
          green         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.letter       = letter;
  assign bus.red          = red;
  assign bus.green        = green;
  assign bus.mistake      = mistake;
  assign bus.incorrect    = incorrect;
  assign bus.correct      = correct;
  assign bus.indexCorrect = index_correct;
  assign bus.red_busy     = comparing;
  assign bus.game_rdy     = (state == IDLE);

endmodule

// File: tb/tb_game_logic.sv
// Scoreboard bench for game_logic: word-level hangman model feeds expectations to a monitor.
module tb_game_logic;
  localparam int MAXM = 6;

  logic clk;
  logic nRst;
  game_logic_if bus();

  game_logic #(.MAX_MISTAKES(MAXM)) dut (.clk(clk), .nRst(nRst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] letter;
    logic [4:0] idx;
    logic [2:0] cor;
    logic [2:0] inc;
    logic       red;
    logic       green;
    logic       mis;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int eval_count = 0;
  int busy_run = 0;
  int mistake_cycles = 0;

  // Reference model of one game, kept at the level of letters and positions.
  logic [7:0] mw[5];
  bit         mrev[5];
  int         mmis;
  bit         mover;
  bit         mpend;
  logic [7:0] mlast = 8'h00;
  int         miss_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fold(input logic [7:0] g);
`ifdef GAME_LOGIC_CASE_FOLD_EN
    return (g >= 8'h61 && g <= 8'h7A) ? (g & 8'hDF) : g;
`else
    return g;
`endif
  endfunction

  function automatic logic [39:0] pack(input string s);
    return {s[0], s[1], s[2], s[3], s[4]};
  endfunction

  function automatic exp_t model_eval(input logic [7:0] gf);
    exp_t e;
    bit hit;
    int c;
    hit = 0;
    c = 0;
    for (int i = 0; i < 5; i++)
      if (mw[i] == gf) begin mrev[i] = 1; hit = 1; end
    for (int i = 0; i < 5; i++) c += int'(mrev[i]);
    if (!hit) begin
      if (mmis < MAXM) mmis++;
      miss_total++;
    end
    mover = (c == 5) || (mmis == MAXM);
    mlast = gf;
    mpend = 0;
    e.letter = gf;
    e.idx    = {mrev[0], mrev[1], mrev[2], mrev[3], mrev[4]};
    e.cor    = 3'(c);
    e.inc    = 3'(mmis);
    e.red    = !hit;
    e.green  = hit;
    e.mis    = !hit;
    e.rdy    = !mover;
    return e;
  endfunction

  // Monitor: an evaluation is complete on the first cycle red_busy drops.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mistake === 1'b1) mistake_cycles++;
    if (bus.red_busy === 1'b1) begin
      busy_run++;
    end else if (busy_run != 0) begin
      chk("busy_len", 64'(busy_run), 64'd5);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_eval actual=evaluation required=none t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("letter",       64'(bus.letter),       64'(e.letter));
        chk("indexCorrect", 64'(bus.indexCorrect), 64'(e.idx));
        chk("correct",      64'(bus.correct),      64'(e.cor));
        chk("incorrect",    64'(bus.incorrect),    64'(e.inc));
        chk("red",          64'(bus.red),          64'(e.red));
        chk("green",        64'(bus.green),        64'(e.green));
        chk("mistake",      64'(bus.mistake),      64'(e.mis));
        chk("game_rdy",     64'(bus.game_rdy),     64'(e.rdy));
      end
      eval_count++;
      busy_run = 0;
    end
  end

  task automatic wait_eval(input int n0);
    int k;
    k = 0;
    while (eval_count == n0 && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    chk("eval_done", 64'(eval_count != n0), 64'd1);
  endtask

  task automatic press();
    @(negedge clk); #1;
    bus.toggle_state = 1'b1;
    @(negedge clk); #1;
    bus.toggle_state = 1'b0;
    @(negedge clk); #1;
  endtask

  // From SET: latch the word; the guess on the bus is evaluated right away.
  task automatic start_game(input logic [39:0] w, input logic [7:0] g);
    int n0;
    bus.setWord = w;
    bus.guess   = g;
    for (int i = 0; i < 5; i++) begin
      mw[i]   = w[39-8*i -: 8];
      mrev[i] = 0;
    end
    mmis  = 0;
    mover = 0;
    mpend = 1;
    exp_q.push_back(model_eval(fold(g)));
    n0 = eval_count;
    @(negedge clk); #1;
    bus.toggle_state = 1'b1;
    @(negedge clk); #1;
    bus.toggle_state = 1'b0;
    wait_eval(n0);
  endtask

  task automatic do_guess(input logic [7:0] g);
    logic [7:0] gf;
    int n0;
    int k;
    gf = fold(g);
    if (!mpend && gf == mlast) return;
    k = 0;
    while (bus.game_rdy !== 1'b1 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rdy_before_guess", 64'(bus.game_rdy), 64'd1);
    bus.guess = g;
    exp_q.push_back(model_eval(gf));
    n0 = eval_count;
    wait_eval(n0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string seq;
    int n0;
    int base;
    int cnt;
    logic [39:0] w;
    logic [7:0] g;

    bus.guess = 8'h00;
    bus.setWord = '0;
    bus.toggle_state = 1'b1;
    nRst = 1'b1;
    repeat (3) @(negedge clk);
    #1 nRst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_letter", 64'(bus.letter), 0);
    chk("rst_red", 64'(bus.red), 0);
    chk("rst_green", 64'(bus.green), 0);
    chk("rst_mistake", 64'(bus.mistake), 0);
    chk("rst_busy", 64'(bus.red_busy), 0);
    chk("rst_game_rdy", 64'(bus.game_rdy), 0);
    chk("rst_incorrect", 64'(bus.incorrect), 0);
    chk("rst_correct", 64'(bus.correct), 0);
    chk("rst_index", 64'(bus.indexCorrect), 0);
    bus.toggle_state = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("no_start_after_reset", 64'(bus.game_rdy), 0);

    // All-miss game ending in a loss.
    base = mistake_cycles;
    start_game(pack("APPLE"), "C");
    seq = "JQRKM";
    for (int i = 0; i < 5; i++) begin
      repeat (50) @(negedge clk);
      #1;
      do_guess(seq[i]);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("loss_red", 64'(bus.red), 1);
    chk("loss_rdy", 64'(bus.game_rdy), 0);
    chk("loss_pulses", 64'(mistake_cycles - base), 6);

    press();
    chk("clr_letter", 64'(bus.letter), 0);
    chk("clr_red", 64'(bus.red), 0);
    chk("clr_incorrect", 64'(bus.incorrect), 0);
    chk("clr_correct", 64'(bus.correct), 0);
    chk("clr_index", 64'(bus.indexCorrect), 0);
    chk("clr_rdy", 64'(bus.game_rdy), 0);

    // All-hit game with a repeated letter.
    start_game(pack("APPLE"), "A");
    seq = "PLE";
    for (int i = 0; i < 3; i++) do_guess(seq[i]);
    repeat (3) @(negedge clk);
    #1;
    chk("win_green", 64'(bus.green), 1);
    chk("win_index", 64'(bus.indexCorrect), 64'h1F);
    chk("win_rdy", 64'(bus.game_rdy), 0);

    press();
    start_game(pack("MOORE"), "M");
    do_guess("A");
    n0 = eval_count;
    repeat (100) @(negedge clk);
    #1;
    chk("hold_no_eval", 64'(eval_count), 64'(n0));
    chk("hold_incorrect", 64'(bus.incorrect), 1);
    chk("hold_correct", 64'(bus.correct), 1);
    press();
    repeat (10) @(negedge clk);
    #1;
    chk("idle_press_rdy", 64'(bus.game_rdy), 1);
    chk("idle_press_no_eval", 64'(eval_count), 64'(n0));
    seq = "ORE";
    for (int i = 0; i < 3; i++) do_guess(seq[i]);

    // New game whose first guess equals the previous game's last guess.
    press();
    start_game(pack("EAGLE"), "E");
    seq = "AGL";
    for (int i = 0; i < 3; i++) do_guess(seq[i]);

    for (int gm = 0; gm < 14; gm++) begin
      for (int i = 0; i < 5; i++) w[39-8*i -: 8] = 8'h41 + 8'($urandom_range(0, 7));
      g = 8'h41 + 8'($urandom_range(0, 11));
      if ($urandom_range(0, 4) == 0) g = g | 8'h20;
      press();
      start_game(w, g);
      cnt = 0;
      while (!mover && cnt < 300) begin
        g = 8'h41 + 8'($urandom_range(0, 11));
        if ($urandom_range(0, 4) == 0) g = g | 8'h20;
        do_guess(g);
        cnt++;
      end
      chk("random_game_over", 64'(mover), 1);
    end

    repeat (10) @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 0);
    chk("mistake_total", 64'(mistake_cycles), 64'(miss_total));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
